// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// pipe_hazard_ctrl : stall / bubble / flush controller for the in-order pipe.
// Optional macro PIPE_PERF_CNT_EN adds stall, flush and load-use counters.
// Revision : 1.0
// =============================================================================
module pipe_hazard_ctrl #(
    parameter  int MEM_STAGES = 1,
    parameter  int REG_ADDR_W = 5,
    parameter  int MC_CNT_W   = 6,
    localparam int NUM_STAGES = 4 + MEM_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic                  id_rs1_re,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs2_re,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_regfile_we,
    input  logic [REG_ADDR_W-1:0] id_regfile_waddr,
    input  logic                  id_mem_re,
    input  logic                  id_mc,
    input  logic [MC_CNT_W-1:0]   id_mc_cycles,
    input  logic                  ex_branch_taken,
    output logic                  pc_we,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [NUM_STAGES-1:0] valid_o,
    output logic                  mc_busy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_lu_cnt
`endif
);

    // Loads become forwardable after the last MEM stage, so destination
    // records are only needed from EX up to the stage just before it.
    localparam int LU_LAST = 1 + MEM_STAGES;
    localparam logic [MC_CNT_W-1:0] MC_ONE = MC_CNT_W'(1);

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [LU_LAST:2]      we_q, we_d;
    logic [LU_LAST:2]      load_q, load_d;
    logic [REG_ADDR_W-1:0] waddr_q [2:LU_LAST];
    logic [REG_ADDR_W-1:0] waddr_d [2:LU_LAST];
    logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;

    logic             started;
    logic             lu;
    logic             fl;
    logic             mc_start;
    logic [LU_LAST:2] lu_hit;

    assign started = valid_q[0];
    assign valid_o = valid_q;
    assign mc_busy = (mc_cnt_q != '0);
    assign fl      = ex_branch_taken & valid_q[2] & ~mc_busy;

    for (genvar k = 2; k <= LU_LAST; k++) begin : g_lu_hit
        assign lu_hit[k] = valid_q[k] & we_q[k] & load_q[k] &
            ((id_rs1_re & (id_rs1_addr != '0) & (id_rs1_addr == waddr_q[k])) |
             (id_rs2_re & (id_rs2_addr != '0) & (id_rs2_addr == waddr_q[k])));
    end

    assign lu = valid_q[1] & (|lu_hit);

    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        pc_we    = 1'b0;
        if (!started) begin
            bubble_o = '1;
        end else if (fl) begin
            bubble_o[1] = 1'b1;
            bubble_o[2] = 1'b1;
            pc_we       = 1'b1;
        end else if (mc_busy) begin
            stall_o[2:0] = '1;
            bubble_o[3]  = 1'b1;
        end else if (lu) begin
            stall_o[1:0] = '1;
            bubble_o[2]  = 1'b1;
        end else begin
            pc_we       = 1'b1;
            bubble_o[1] = ~if_valid;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        we_d       = we_q;
        load_d     = load_q;
        waddr_d    = waddr_q;
        valid_d[0] = 1'b1;

        if (bubble_o[1]) begin
            valid_d[1] = 1'b0;
        end else if (!stall_o[1]) begin
            valid_d[1] = if_valid;
        end

        if (bubble_o[2]) begin
            valid_d[2] = 1'b0;
            we_d[2]    = 1'b0;
            load_d[2]  = 1'b0;
        end else if (!stall_o[2]) begin
            valid_d[2] = valid_q[1];
            we_d[2]    = id_regfile_we;
            load_d[2]  = id_mem_re;
            waddr_d[2] = id_regfile_waddr;
        end

        for (int k = 3; k < NUM_STAGES; k++) begin
            if (bubble_o[k]) begin
                valid_d[k] = 1'b0;
            end else if (!stall_o[k]) begin
                valid_d[k] = valid_q[k-1];
            end
        end

        for (int k = 3; k <= LU_LAST; k++) begin
            if (bubble_o[k]) begin
                we_d[k]   = 1'b0;
                load_d[k] = 1'b0;
            end else if (!stall_o[k]) begin
                we_d[k]    = we_q[k-1];
                load_d[k]  = load_q[k-1];
                waddr_d[k] = waddr_q[k-1];
            end
        end
    end

    // A zero latency field means a single-cycle op: it never raises busy.
    assign mc_start = valid_q[1] & id_mc & ~stall_o[2] & ~bubble_o[2];

    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (mc_start) begin
            mc_cnt_d = (id_mc_cycles == '0) ? '0 : id_mc_cycles - MC_ONE;
        end else if (mc_busy) begin
            mc_cnt_d = mc_cnt_q - MC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            we_q     <= '0;
            load_q   <= '0;
            waddr_q  <= '{default: '0};
            mc_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            we_q     <= we_d;
            load_q   <= load_d;
            waddr_q  <= waddr_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_lu_q, perf_lu_d;
    logic        lu_stall;

    assign lu_stall = lu & ~fl & ~mc_busy;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, ~pc_we};
        perf_flush_d = perf_flush_q + {31'd0, fl};
        perf_lu_d    = perf_lu_q + {31'd0, lu_stall};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_lu_q    <= perf_lu_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cnt    = perf_flush_q;
    assign perf_lu_cnt       = perf_lu_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// tb_pipe_hazard_ctrl : directed vector table plus multi-cycle corner sequences.
// Revision : 1.0
// =============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       if_valid = 1'b1;
    logic       id_rs1_re = 1'b0;
    logic [4:0] id_rs1_addr = 5'd0;
    logic       id_rs2_re = 1'b0;
    logic [4:0] id_rs2_addr = 5'd0;
    logic       id_regfile_we = 1'b0;
    logic [4:0] id_regfile_waddr = 5'd0;
    logic       id_mem_re = 1'b0;
    logic       id_mc = 1'b0;
    logic [5:0] id_mc_cycles = 6'd0;
    logic       ex_branch_taken = 1'b0;

    logic       pc_we1, busy1;
    logic [4:0] stall1, bub1, val1;
    logic       pc_we3, busy3;
    logic [6:0] stall3, bub3, val3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .if_valid(if_valid),
        .id_rs1_re(id_rs1_re), .id_rs1_addr(id_rs1_addr),
        .id_rs2_re(id_rs2_re), .id_rs2_addr(id_rs2_addr),
        .id_regfile_we(id_regfile_we), .id_regfile_waddr(id_regfile_waddr),
        .id_mem_re(id_mem_re), .id_mc(id_mc), .id_mc_cycles(id_mc_cycles),
        .ex_branch_taken(ex_branch_taken),
        .pc_we(pc_we1), .stall_o(stall1), .bubble_o(bub1), .valid_o(val1), .mc_busy(busy1)
    );

    pipe_hazard_ctrl #(.MEM_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .if_valid(if_valid),
        .id_rs1_re(id_rs1_re), .id_rs1_addr(id_rs1_addr),
        .id_rs2_re(id_rs2_re), .id_rs2_addr(id_rs2_addr),
        .id_regfile_we(id_regfile_we), .id_regfile_waddr(id_regfile_waddr),
        .id_mem_re(id_mem_re), .id_mc(id_mc), .id_mc_cycles(id_mc_cycles),
        .ex_branch_taken(ex_branch_taken),
        .pc_we(pc_we3), .stall_o(stall3), .bubble_o(bub3), .valid_o(val3), .mc_busy(busy3)
    );

    typedef struct {
        logic       rst;
        logic       ifv;
        logic       r1e;
        logic [4:0] r1;
        logic       r2e;
        logic [4:0] r2;
        logic       we;
        logic [4:0] wa;
        logic       ld;
        logic       mc;
        logic [5:0] mcc;
        logic       br;
        logic       pc;
        logic [4:0] st;
        logic [4:0] bu;
        logic [4:0] va;
        logic       busy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic rs, input logic ifv,
        input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
        input logic we, input logic [4:0] wa, input logic ld,
        input logic mc, input logic [5:0] mcc, input logic br,
        input logic pc, input logic [4:0] st, input logic [4:0] bu,
        input logic [4:0] va, input logic busy);
        vec_t v;
        v.rst = rs;  v.ifv = ifv; v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2;
        v.we = we;   v.wa = wa;   v.ld = ld;   v.mc = mc; v.mcc = mcc; v.br = br;
        v.pc = pc;   v.st = st;   v.bu = bu;   v.va = va; v.busy = busy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst              = v.rst;
        if_valid         = v.ifv;
        id_rs1_re        = v.r1e;
        id_rs1_addr      = v.r1;
        id_rs2_re        = v.r2e;
        id_rs2_addr      = v.r2;
        id_regfile_we    = v.we;
        id_regfile_waddr = v.wa;
        id_mem_re        = v.ld;
        id_mc            = v.mc;
        id_mc_cycles     = v.mcc;
        ex_branch_taken  = v.br;
    endtask

    task automatic idle_id();
        id_rs1_re = 1'b0; id_rs1_addr = 5'd0; id_rs2_re = 1'b0; id_rs2_addr = 5'd0;
        id_regfile_we = 1'b0; id_regfile_waddr = 5'd0; id_mem_re = 1'b0;
        id_mc = 1'b0; id_mc_cycles = 6'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] e1;
        logic [14:0] e3;

        // Inputs: rst ifv | rs1 | rs2 | we wa ld | mc mcc br || pc stall bubble valid busy
        for (int i = 0; i < 3; i++)
            tv.push_back(mk(1'b0,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b0,5'b00000,5'b11111,5'b00000,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b0,5'b00000,5'b11111,5'b00000,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b00001,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b00011,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b00111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b01111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b1,5'd5,1'b1, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b11111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b1,5'd5,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b0,5'b00011,5'b00100,5'b11111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b1,5'd5,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b11011,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b1,5'd0,1'b1, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b10111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b1,5'd0,1'b1,5'd0, 1'b1,5'd7,1'b1, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b01111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b1,5'd3,1'b1,5'd7, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b0,5'b00011,5'b00100,5'b11111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b1,5'd9,1'b1, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b11011,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b1,5'd9,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b1, 1'b1,5'b00000,5'b00110,5'b10111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b1,5'd9,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b01001,1'b0));
        tv.push_back(mk(1'b1,1'b0, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00010,5'b10011,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b00101,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b1,6'd4,1'b0, 1'b1,5'b00000,5'b00000,5'b01011,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b1, 1'b0,5'b00111,5'b01000,5'b10111,1'b1));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b0,5'b00111,5'b01000,5'b00111,1'b1));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b0,5'b00111,5'b01000,5'b00111,1'b1));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b1,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b00111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b01111,1'b0));
        tv.push_back(mk(1'b1,1'b1, 1'b0,5'd0,1'b0,5'd0, 1'b0,5'd0,1'b0, 1'b0,6'd0,1'b0, 1'b1,5'b00000,5'b00000,5'b11111,1'b0));

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("row%0d", i), {47'd0, pc_we1, stall1, bub1, val1, busy1},
                {47'd0, tv[i].pc, tv[i].st, tv[i].bu, tv[i].va, tv[i].busy});
        end

        // Asynchronous reset during the second busy cycle of a 5-cycle op.
        @(negedge clk);
        idle_id();
        id_mc = 1'b1;
        id_mc_cycles = 6'd5;
        #1 chk("mc5_issue_not_busy", {63'd0, busy1}, 64'd0);
        @(negedge clk);
        idle_id();
        #1 chk("mc5_busy_cycle1", {58'd0, busy1, stall1}, {58'd0, 1'b1, 5'b00111});
        @(negedge clk);
        #1 chk("mc5_busy_cycle2", {63'd0, busy1}, 64'd1);
        rst = 1'b0;
        #1 chk("async_rst_mid_mc", {47'd0, busy1, val1, pc_we1, stall1, bub1},
               {47'd0, 1'b0, 5'b00000, 1'b0, 5'b00000, 5'b11111});
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Refill both pipelines, then load-use on r5 for both memory depths.
        repeat (7) @(negedge clk);
        #1 chk("refill_valid", {52'd0, val3, val1}, {52'd0, 7'h7F, 5'h1F});
        id_regfile_we    = 1'b1;
        id_regfile_waddr = 5'd5;
        id_mem_re        = 1'b1;
        @(negedge clk);
        idle_id();
        id_rs1_re   = 1'b1;
        id_rs1_addr = 5'd5;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            e1 = (i < 1) ? {1'b0, 5'b00011, 5'b00100} : {1'b1, 5'b00000, 5'b00000};
            e3 = (i < 3) ? {1'b0, 7'b0000011, 7'b0000100} : {1'b1, 7'b0000000, 7'b0000000};
            chk($sformatf("lu_mem1_cyc%0d", i), {53'd0, pc_we1, stall1, bub1}, {53'd0, e1});
            chk($sformatf("lu_mem3_cyc%0d", i), {49'd0, pc_we3, stall3, bub3}, {49'd0, e3});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
